approx_err_acc: RTL and testbench

APPROX_ERR_ACC -- requirements
Module: approx_err_acc

---
 rtl/approx_err_acc.sv | 166 ++++++++++++++++
 tb/tb_approx_err_acc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_acc.sv
// approx_err_acc: accumulates |A*B - result| statistics over a run of samples.
// Optional APPROX_ERR_SQ_EN adds sq_sum, the running sum of squared errors.
module approx_err_acc #(
  parameter int CNT_W = 24,
  parameter int SUM_W = 32 + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  input  logic [31:0]      result,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] err_sum,
  output logic [31:0]      err_max,
  output logic [CNT_W-1:0] err_cnt
`ifdef APPROX_ERR_SQ_EN
  ,
  output logic [64+CNT_W-1:0] sq_sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_acc;

  logic             r_v1;
  logic [31:0]      r_exact;
  logic [31:0]      r_res;
  logic             r_v2;
  logic [31:0]      r_err;

  logic [SUM_W-1:0] r_sum;
  logic [31:0]      r_max;
  logic [CNT_W-1:0] r_cnt;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_exact;
  logic [31:0]      w_err;

  assign w_start_ok = start &&
    (r_state == S_IDLE || r_state == S_DONE);
  assign in_ready = (r_state == S_RUN) &&
    (r_acc < r_count);
  assign w_accept = in_valid && in_ready;
  assign w_last = w_accept &&
    (r_acc == r_count - CNT_W'(1));

  assign w_exact = {16'd0, A} * {16'd0, B};
  assign w_err = (r_exact >= r_res) ?
    (r_exact - r_res) : (r_res - r_exact);

  assign busy = (r_state == S_RUN) ||
    (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

  assign err_sum = r_sum;
  assign err_max = r_max;
  assign err_cnt = r_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: drain finishes when the last sample leaves stage 2.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok)
          w_next = (sample_count == '0) ?
            S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_v2 && !r_v1) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Run length latch and accepted-sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_acc   <= '0;
    end else if (w_start_ok) begin
      r_count <= sample_count;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_acc <= r_acc + CNT_W'(1);
    end
  end

  // Stages 1 and 2: exact product, then absolute error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_exact <= '0;
      r_res   <= '0;
      r_v2    <= 1'b0;
      r_err   <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_exact <= w_exact;
        r_res   <= result;
      end
      r_v2 <= r_v1;
      if (r_v1) r_err <= w_err;
    end
  end

  // Stage 3: fold the error into the run statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (r_v2) begin
      r_sum <= r_sum + SUM_W'(r_err);
      if (r_err > r_max) r_max <= r_err;
      if (r_err != '0) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef APPROX_ERR_SQ_EN
  logic [63:0]         w_sq;
  logic [64+CNT_W-1:0] r_sq;

  assign w_sq = {32'd0, r_err} * {32'd0, r_err};
  assign sq_sum = r_sq;

  // Stage 3 companion: squared-error accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_sq <= '0;
    else if (w_start_ok) r_sq <= '0;
    else if (r_v2)
      r_sq <= r_sq + (64+CNT_W)'(w_sq);
  end
`endif

endmodule

// File: tb/tb_approx_err_acc.sv
// Scoreboard bench for approx_err_acc: driver pushes per-run
// expectations, monitor checks them when done rises.
module tb_approx_err_acc;
  localparam int CNT_W = 24;
  localparam int SUM_W = 56;
  localparam int SQ_W  = 64 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] sample_count;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      A;
  logic [15:0]      B;
  logic [31:0]      result;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] err_sum;
  logic [31:0]      err_max;
  logic [CNT_W-1:0] err_cnt;
`ifdef APPROX_ERR_SQ_EN
  logic [SQ_W-1:0]  sq_sum;
`endif

  approx_err_acc #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sample_count(sample_count),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .result(result),
    .busy(busy), .done(done),
    .err_sum(err_sum), .err_max(err_max),
    .err_cnt(err_cnt)
`ifdef APPROX_ERR_SQ_EN
    , .sq_sum(sq_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic [31:0]      mx;
    logic [CNT_W-1:0] cnt;
    logic [SQ_W-1:0]  sq;
    int               n;
  } exp_t;

  exp_t        q[$];
  exp_t        last_e;
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          acc_n = 0;
  logic        pdone = 1'b0;
  logic [15:0] sa[8];
  logic [15:0] sb[8];
  logic [31:0] sr[8];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Monitor: count accepts, score each run as done rises.
  always @(negedge clk) begin
    if (rst) begin
      acc_n = 0;
      pdone = 1'b0;
    end else begin
      if (done && !pdone) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          mon_e = q.pop_front();
          chk("err_sum", err_sum, mon_e.sum);
          chk("err_max", err_max, mon_e.mx);
          chk("err_cnt", err_cnt, mon_e.cnt);
          chk("accepted", acc_n, mon_e.n);
`ifdef APPROX_ERR_SQ_EN
          chk("sq_sum", sq_sum, mon_e.sq);
`endif
        end
      end
      pdone = done;
      if (in_valid && in_ready) acc_n++;
      if (start && !busy) begin
        acc_n = 0;
        pdone = 1'b0;
      end
    end
  end

  function automatic exp_t model(input int n);
    exp_t   e;
    longint d;
    e.sum = '0;
    e.mx  = '0;
    e.cnt = '0;
    e.sq  = '0;
    e.n   = n;
    for (int i = 0; i < n; i++) begin
      d = longint'(sa[i]) * longint'(sb[i])
          - longint'(sr[i]);
      if (d < 0) d = -d;
      e.sum = e.sum + SUM_W'(d);
      if (d > longint'(e.mx)) e.mx = 32'(d);
      if (d != 0) e.cnt = e.cnt + 1'b1;
      e.sq = e.sq + SQ_W'(d) * SQ_W'(d);
    end
    return e;
  endfunction

  task automatic set_s(input int i, input int a,
                       input int b, input longint r);
    sa[i] = 16'(a);
    sb[i] = 16'(b);
    sr[i] = 32'(r);
  endtask

  task automatic gen(input int n);
    logic [31:0] ex;
    for (int i = 0; i < n; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      ex = {16'd0, sa[i]} * {16'd0, sb[i]};
      case ($urandom_range(0, 3))
        0: sr[i] = ex;
        1: sr[i] = ex + $urandom_range(1, 5000);
        2: sr[i] = ex - $urandom_range(1, 5000);
        default: sr[i] = $urandom;
      endcase
    end
  endtask

  task automatic pulse_start(input int n);
    sample_count = CNT_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: toggling, 2: random gaps
  task automatic feed(input int n, input int mode,
                      input int mid_start,
                      input int stop_at);
    int i = 0;
    int cyc = 0;
    logic v;
    while (i < n && i < stop_at) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = ($urandom_range(0, 2) != 0);
      start = (cyc == mid_start);
      if (cyc == mid_start) sample_count = CNT_W'(1);
      in_valid = v;
      A = sa[i];
      B = sb[i];
      result = sr[i];
      @(negedge clk);
      if (v && in_ready) i++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 4000) begin
        checks++;
        failures++;
        $display("FAIL feed_timeout: got %0d expected %0d",
                 i, n);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run(input int n, input int mode,
                     input int mid_start);
    last_e = model(n);
    q.push_back(last_e);
    pulse_start(n);
    if (n == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_ready", in_ready, 0);
      @(posedge clk); #1;
    end else begin
      feed(n, mode, mid_start, n);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("ready_after_last", in_ready, 0);
        chk("done_latency", done, (k == 2));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_hold", done, 1);
    chk("sum_hold", err_sum, last_e.sum);
    chk("idle_ready", in_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sample_count = '0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    result = '0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_sum", err_sum, 0);
    chk("rst_max", err_max, 0);
    chk("rst_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, -1);

    set_s(0, 3, 5, 15);
    set_s(1, 100, 200, 20000);
    set_s(2, 65535, 65535, 64'd4294836225);
    run(3, 0, -1);

    set_s(0, 1000, 1000, 999000);
    set_s(1, 2, 3, 7);
    run(2, 0, -1);

    gen(4);
    run(4, 1, -1);

    gen(5);
    run(5, 0, 2);

    gen(5);
    pulse_start(5);
    feed(5, 0, -1, 2);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_sum", err_sum, 0);
    chk("abort_max", err_max, 0);
    chk("abort_cnt", err_cnt, 0);
`ifdef APPROX_ERR_SQ_EN
    chk("abort_sq", sq_sum, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    gen(3);
    run(3, 0, -1);

    for (int r = 0; r < 6; r++) begin
      gen($urandom_range(1, 8));
      run($urandom_range(1, 8), 2, -1);
    end

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
